score_keeper: RTL and testbench

- Consumes the ball datapath's `player_0_scores` / `player_1_scores` level flags.
- Keeps per-player two-digit BCD scores for the HEX displays.
- Runs the match FSM: idle, play, post-point hold, game over.
- Drives `game_active`, which gates the ball controller's `go`. The ball is frozen whenever this block is not in PLAY.

---
 rtl/score_keeper_pkg.sv | 28 ++
 rtl/score_keeper_if.sv | 21 ++
 rtl/score_keeper_bcd_counter_2d.sv | 51 +++++
 rtl/score_keeper.sv | 159 +++++++++++++++
 tb/tb_score_keeper.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/score_keeper_pkg.sv
// Shared FSM state codes, winner codes and score helpers for score_keeper.
// The SCORE_DEUCE_EN build option is handled in score_keeper.sv.
package score_pkg;

  typedef logic [1:0] state_t;
  typedef logic [1:0] winner_t;

  localparam state_t IDLE      = 2'd0;
  localparam state_t PLAY      = 2'd1;
  localparam state_t POINT     = 2'd2;
  localparam state_t GAME_OVER = 2'd3;

  localparam winner_t WIN_NONE = 2'b00;
  localparam winner_t WIN_P0   = 2'b01;
  localparam winner_t WIN_P1   = 2'b10;

  localparam logic [6:0] SCORE_MAX = 7'd99;

  // Count after one more point; it stays put once the display saturates.
  function automatic logic [6:0] next_count(input logic [6:0] cnt);
    if (cnt == SCORE_MAX) begin
      return cnt;
    end else begin
      return cnt + 7'd1;
    end
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Match-level signal bundle between the ball datapath/controller and score_keeper.
interface score_keeper_if;
  logic       start;
  logic       player_0_scores;
  logic       player_1_scores;
  logic [7:0] score_0;
  logic [7:0] score_1;
  logic       game_active;
  logic       point_flash;
  logic [1:0] winner;

  modport master (
    output start, player_0_scores, player_1_scores,
    input  score_0, score_1, game_active, point_flash, winner
  );

  modport slave (
    input  start, player_0_scores, player_1_scores,
    output score_0, score_1, game_active, point_flash, winner
  );
endinterface

// File: rtl/score_keeper_bcd_counter_2d.sv
// Two-digit BCD score counter with a parallel binary count, saturating at 99.
module bcd_counter_2d
  import score_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       inc,
  output logic [7:0] bcd,
  output logic [6:0] bin
);

  logic [7:0] bcd_q, bcd_d;
  logic [6:0] bin_q, bin_d;

  // Next count: clear wins over increment; the increment stops at 99.
  always_comb begin
    bcd_d = bcd_q;
    bin_d = bin_q;
    if (clear) begin
      bcd_d = 8'h00;
      bin_d = 7'd0;
    end else if (inc && (bin_q != SCORE_MAX)) begin
      bin_d = bin_q + 7'd1;
      if (bcd_q[3:0] == 4'd9) begin
        bcd_d[3:0] = 4'd0;
        bcd_d[7:4] = bcd_q[7:4] + 4'd1;
      end else begin
        bcd_d[3:0] = bcd_q[3:0] + 4'd1;
      end
    end else begin
      bcd_d = bcd_q;
      bin_d = bin_q;
    end
  end

  // Count registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bcd_q <= 8'h00;
      bin_q <= 7'd0;
    end else begin
      bcd_q <= bcd_d;
      bin_q <= bin_d;
    end
  end

  assign bcd = bcd_q;
  assign bin = bin_q;

endmodule

// File: rtl/score_keeper.sv
// Pong match FSM: per-player BCD scores, post-point hold and winner detection.
// Define SCORE_DEUCE_EN to require a two-point lead at or above WIN_SCORE.
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned HOLD_W      = 26
) (
  input  logic           clk,
  input  logic           resetn,
  score_keeper_if.slave  sk
);

  logic              start_q, p0_q, p1_q;
  logic              rise_start_s, rise_p0_s, rise_p1_s;
  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  winner_t           winner_q, winner_d;
  logic              game_active_q, point_flash_q;
  logic              inc0_s, inc1_s, clear_s;
  logic              win0_s, win1_s;
  logic [6:0]        bin0_s, bin1_s, new0_s, new1_s;
  logic [7:0]        bcd0_s, bcd1_s;

  // Edge history starts high so a level already asserted at reset release is not an edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      start_q <= 1'b1;
      p0_q    <= 1'b1;
      p1_q    <= 1'b1;
    end else begin
      start_q <= sk.start;
      p0_q    <= sk.player_0_scores;
      p1_q    <= sk.player_1_scores;
    end
  end

  assign rise_start_s = sk.start & ~start_q;
  assign rise_p0_s    = sk.player_0_scores & ~p0_q;
  assign rise_p1_s    = sk.player_1_scores & ~p1_q;

  // Simultaneous edges are a tie and count for nobody.
  assign inc0_s  = (state_q == PLAY) & rise_p0_s & ~rise_p1_s;
  assign inc1_s  = (state_q == PLAY) & rise_p1_s & ~rise_p0_s;
  assign clear_s = (state_q == GAME_OVER) & rise_start_s;

  assign new0_s = next_count(bin0_s);
  assign new1_s = next_count(bin1_s);

`ifdef SCORE_DEUCE_EN
  assign win0_s = (new0_s >= 7'(WIN_SCORE)) &&
                  ((new0_s == SCORE_MAX) || ({1'b0, new0_s} >= ({1'b0, bin1_s} + 8'd2)));
  assign win1_s = (new1_s >= 7'(WIN_SCORE)) &&
                  ((new1_s == SCORE_MAX) || ({1'b0, new1_s} >= ({1'b0, bin0_s} + 8'd2)));
`else
  assign win0_s = (new0_s >= 7'(WIN_SCORE));
  assign win1_s = (new1_s >= 7'(WIN_SCORE));
`endif

  bcd_counter_2d u_cnt0 (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear_s),
    .inc    (inc0_s),
    .bcd    (bcd0_s),
    .bin    (bin0_s)
  );

  bcd_counter_2d u_cnt1 (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear_s),
    .inc    (inc1_s),
    .bcd    (bcd1_s),
    .bin    (bin1_s)
  );

  // Match FSM next-state, hold timer and winner.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    winner_d = winner_q;
    case (state_q)
      IDLE: begin
        if (rise_start_s) begin
          state_d = PLAY;
        end else begin
          state_d = IDLE;
        end
      end
      PLAY: begin
        if (inc0_s) begin
          if (win0_s) begin
            state_d  = GAME_OVER;
            winner_d = WIN_P0;
          end else begin
            state_d = POINT;
            hold_d  = '0;
          end
        end else if (inc1_s) begin
          if (win1_s) begin
            state_d  = GAME_OVER;
            winner_d = WIN_P1;
          end else begin
            state_d = POINT;
            hold_d  = '0;
          end
        end else begin
          state_d = PLAY;
        end
      end
      POINT: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d = PLAY;
        end else begin
          hold_d = hold_q + {{(HOLD_W-1){1'b0}}, 1'b1};
        end
      end
      GAME_OVER: begin
        if (rise_start_s) begin
          state_d  = PLAY;
          winner_d = WIN_NONE;
        end else begin
          state_d = GAME_OVER;
        end
      end
      default: begin
        state_d  = IDLE;
        hold_d   = '0;
        winner_d = WIN_NONE;
      end
    endcase
  end

  // State and registered outputs, decoded from the next state so they track it exactly.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      winner_q      <= WIN_NONE;
      game_active_q <= 1'b0;
      point_flash_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      winner_q      <= winner_d;
      game_active_q <= (state_d == PLAY);
      point_flash_q <= (state_d == POINT);
    end
  end

  assign sk.score_0     = bcd0_s;
  assign sk.score_1     = bcd1_s;
  assign sk.game_active = game_active_q;
  assign sk.point_flash = point_flash_q;
  assign sk.winner      = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed, table-driven bench for score_keeper with a short hold time.
module tb_score_keeper;

  localparam int H = 10;
`ifdef SCORE_DEUCE_EN
  localparam int WIN = 7;
`else
  localparam int WIN = 12;
`endif

  typedef struct {
    logic       st;
    logic       p0;
    logic       p1;
    logic [7:0] s0;
    logic [7:0] s1;
    logic       ga;
    logic       pf;
    logic [1:0] w;
  } vec_t;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  int   passes = 0;
  int   total  = 0;
  int   c0     = 0;
  int   c1     = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  score_keeper_if sk ();

  score_keeper #(
    .WIN_SCORE   (WIN),
    .HOLD_CYCLES (H),
    .HOLD_W      (4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .sk     (sk)
  );

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                         input logic ga, input logic pf, input logic [1:0] w);
    chk({tag, ".score_0"}, sk.score_0, s0);
    chk({tag, ".score_1"}, sk.score_1, s1);
    chk({tag, ".game_active"}, {7'd0, sk.game_active}, {7'd0, ga});
    chk({tag, ".point_flash"}, {7'd0, sk.point_flash}, {7'd0, pf});
    chk({tag, ".winner"}, {6'd0, sk.winner}, {6'd0, w});
  endtask

  task automatic step(input logic st, input logic p0, input logic p1);
    sk.start           = st;
    sk.player_0_scores = p0;
    sk.player_1_scores = p1;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic st, input logic p0, input logic p1, input logic [7:0] s0,
                      input logic [7:0] s1, input logic ga, input logic pf, input logic [1:0] w);
    vec_t v;
    v.st = st; v.p0 = p0; v.p1 = p1; v.s0 = s0; v.s1 = s1; v.ga = ga; v.pf = pf; v.w = w;
    vecs.push_back(v);
  endtask

  // One-cycle pulse from PLAY; then either the win or the full hold back to PLAY.
  task automatic score_point(input int who, input logic expect_win);
    step(1'b0, who == 0, who == 1);
    if (who == 0) c0++; else c1++;
    if (expect_win) begin
      chk_all("win", to_bcd(c0), to_bcd(c1), 1'b0, 1'b0, (who == 0) ? 2'b01 : 2'b10);
    end else begin
      chk_all("point", to_bcd(c0), to_bcd(c1), 1'b0, 1'b1, 2'b00);
      repeat (H - 2) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk_all("hold_last", to_bcd(c0), to_bcd(c1), 1'b0, 1'b1, 2'b00);
      step(1'b0, 1'b0, 1'b0);
      chk_all("hold_done", to_bcd(c0), to_bcd(c1), 1'b1, 1'b0, 2'b00);
    end
  endtask

  initial begin
    sk.start = 1'b0;
    sk.player_0_scores = 1'b1;
    sk.player_1_scores = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk_all("reset", 8'h00, 8'h00, 1'b0, 1'b0, 2'b00);
    #10 resetn = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    chk_all("idle_p0_high", 8'h00, 8'h00, 1'b0, 1'b0, 2'b00);

    // Start, a 5-cycle player 1 level, the hold, ties and an ignored start in PLAY.
    push(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00);
    push(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00);
    push(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) push(1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b1, 2'b00);
    for (int i = 5; i < H; i++) push(1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1, 2'b00);
    push(1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0, 2'b00);
    push(1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 1'b1, 1'b0, 2'b00);
    push(1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0, 2'b00);
    push(1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 1'b1, 1'b0, 2'b00);
    push(1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0, 2'b00);
    push(1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0, 2'b00);
    push(1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0, 2'b00);
    foreach (vecs[i]) begin
      step(vecs[i].st, vecs[i].p0, vecs[i].p1);
      chk_all($sformatf("vec%0d", i), vecs[i].s0, vecs[i].s1, vecs[i].ga, vecs[i].pf, vecs[i].w);
    end
    c0 = 0;
    c1 = 1;

`ifdef SCORE_DEUCE_EN
    repeat (5) score_point(1, 1'b0);
    repeat (6) score_point(0, 1'b0);
    chk("deuce_6_6", sk.score_1, 8'h06);
    score_point(0, 1'b0);
    chk("deuce_7_6", sk.score_0, 8'h07);
    score_point(0, 1'b1);
    chk("deuce_8_6", sk.score_0, 8'h08);
`else
    for (int i = 1; i < WIN; i++) begin
      score_point(0, 1'b0);
      if (c0 == 9) chk("bcd_9", sk.score_0, 8'h09);
      if (c0 == 10) chk("bcd_10", sk.score_0, 8'h10);
    end
    score_point(0, 1'b1);
    chk("win_12", sk.score_0, 8'h12);
`endif

    // GAME_OVER freezes everything until a start edge.
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk_all("frozen", to_bcd(c0), to_bcd(c1), 1'b0, 1'b0, 2'b01);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    c0 = 0;
    c1 = 0;
    chk_all("restart", 8'h00, 8'h00, 1'b1, 1'b0, 2'b00);

    // Async reset in the middle of the hold.
    step(1'b0, 1'b1, 1'b0);
    chk_all("pre_reset_point", 8'h01, 8'h00, 1'b0, 1'b1, 2'b00);
    step(1'b0, 1'b0, 1'b0);
    resetn = 1'b0;
    #1;
    chk_all("async_reset", 8'h00, 8'h00, 1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk_all("idle_ignores_score", 8'h00, 8'h00, 1'b0, 1'b0, 2'b00);
    step(1'b1, 1'b0, 1'b0);
    chk_all("idle_start", 8'h00, 8'h00, 1'b1, 1'b0, 2'b00);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
